inst_queue: RTL and testbench

Decoupling buffer between the branch-prediction/fetch front end and decode. It accepts fetch groups of up to two instructions per cycle, each group carrying the address produced by the predictor. Valid slots are compacted into a circular queue. It presents up to two oldest instructions per cycle to decode in program order. It back-pressures fetch when fewer than two free entries remain, and is emptied by pipeline flush.

---
 rtl/inst_queue.sv | 147 ++++++++++++++
 tb/tb_inst_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode.
// Two-wide enqueue of predicted fetch groups, two-wide in-order dequeue.
module inst_queue #(
    parameter int DEPTH  = 8,
    parameter int META_W = 36
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [1:0]            enq_valid_i,
    input  logic [31:0]           enq_pc_i,
    input  logic [63:0]           enq_inst_i,
    input  logic [META_W-1:0]     enq_meta_i,
    output logic                  enq_ready_o,
    output logic [1:0]            deq_valid_o,
    output logic [63:0]           deq_pc_o,
    output logic [63:0]           deq_inst_o,
    output logic [2*META_W-1:0]   deq_meta_o,
    input  logic [1:0]            deq_ready_i,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [29:0]       pc;
        logic [31:0]       inst;
        logic [META_W-1:0] meta;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    logic [AW-1:0] head_nx1;
    logic [AW-1:0] tail_nx1;
    logic          enq_go;
    logic [1:0]    n_enq;
    logic [1:0]    n_deq;
    logic [1:0]    deq_take;
    entry_t        slot0;
    entry_t        slot1;
    entry_t        wr0_data;
    logic          wr0_en;
    logic          wr1_en;
    entry_t        rd0;
    entry_t        rd1;

    // Low address bits are implied by slot position
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^enq_pc_i[2:0];

    assign head_nx1 = head + 1'b1;
    assign tail_nx1 = tail + 1'b1;

    // Space check uses registered count only
    assign enq_ready_o = (count <= CW'(DEPTH - 2));

    assign enq_go = (|enq_valid_i) & enq_ready_o & ~flush_i;

    // Popcount of accepted slots, zero when the group is not taken
    always_comb begin
        n_enq = 2'd0;
        if (enq_go) begin
            n_enq = {1'b0, enq_valid_i[0]} + {1'b0, enq_valid_i[1]};
        end
    end

    // Thermometer valid from occupancy, killed during flush
    always_comb begin
        deq_valid_o = 2'b00;
        if (!flush_i) begin
            deq_valid_o[0] = (count >= CW'(1));
            deq_valid_o[1] = (count >= CW'(2));
        end
    end

    assign deq_take = deq_valid_o
                    & {deq_ready_i[1] & deq_ready_i[0], deq_ready_i[0]};
    assign n_deq    = {1'b0, deq_take[0]} + {1'b0, deq_take[1]};

    // Build the two candidate entries from the incoming group
    always_comb begin
        slot0      = '0;
        slot1      = '0;
        slot0.pc   = {enq_pc_i[31:3], 1'b0};
        slot0.inst = enq_inst_i[31:0];
        slot0.meta = enq_meta_i;
        slot1.pc   = {enq_pc_i[31:3], 1'b1};
        slot1.inst = enq_inst_i[63:32];
        slot1.meta = enq_meta_i;
    end

    // Compaction: the lowest valid slot always lands at tail
    always_comb begin
        wr0_en   = enq_go;
        wr1_en   = enq_go & (&enq_valid_i);
        wr0_data = enq_valid_i[0] ? slot0 : slot1;
    end

    // Storage writes; flush leaves contents untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr0_en) begin
                mem[tail] <= wr0_data;
            end
            if (wr1_en) begin
                mem[tail_nx1] <= slot1;
            end
        end
    end

    // Pointer and occupancy update, flush has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(n_deq);
            tail  <= tail + AW'(n_enq);
            count <= count + CW'(n_enq) - CW'(n_deq);
        end
    end

    // Combinational read of the two oldest entries
    always_comb begin
        rd0 = mem[head];
        rd1 = mem[head_nx1];
    end

    assign deq_pc_o   = {rd1.pc, 2'b00, rd0.pc, 2'b00};
    assign deq_inst_o = {rd1.inst, rd0.inst};
    assign deq_meta_o = {rd1.meta, rd0.meta};
    assign count_o    = count;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue.
// Expected entries queued on enqueue, compared on dequeue.
module tb_inst_queue;

    localparam int DEPTH  = 8;
    localparam int META_W = 36;

    logic                 clk;
    logic                 rst;
    logic                 flush_i;
    logic [1:0]           enq_valid_i;
    logic [31:0]          enq_pc_i;
    logic [63:0]          enq_inst_i;
    logic [META_W-1:0]    enq_meta_i;
    logic                 enq_ready_o;
    logic [1:0]           deq_valid_o;
    logic [63:0]          deq_pc_o;
    logic [63:0]          deq_inst_o;
    logic [2*META_W-1:0]  deq_meta_o;
    logic [1:0]           deq_ready_i;
    logic [3:0]           count_o;

    typedef struct {
        logic [31:0]       pc;
        logic [31:0]       inst;
        logic [META_W-1:0] meta;
    } exp_t;

    exp_t sb[$];
    int   n_chk;
    int   n_fail;

    inst_queue #(.DEPTH(DEPTH), .META_W(META_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .enq_valid_i (enq_valid_i),
        .enq_pc_i    (enq_pc_i),
        .enq_inst_i  (enq_inst_i),
        .enq_meta_i  (enq_meta_i),
        .enq_ready_o (enq_ready_o),
        .deq_valid_o (deq_valid_o),
        .deq_pc_o    (deq_pc_o),
        .deq_inst_o  (deq_inst_o),
        .deq_meta_o  (deq_meta_o),
        .deq_ready_i (deq_ready_i),
        .count_o     (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, check against the model, advance to next negedge
    task automatic step(input logic [1:0] v, input logic [31:0] pc,
                        input logic [63:0] inst, input logic [1:0] dr,
                        input logic fl);
        logic [1:0]        ev;
        logic              rdy;
        logic [META_W-1:0] meta;
        int                n;
        int                sz;
        exp_t              e;
        meta        = {4'(pc[6:3]) ^ 4'(inst[3:0]), pc};
        enq_valid_i = v;
        enq_pc_i    = pc;
        enq_inst_i  = inst;
        enq_meta_i  = meta;
        deq_ready_i = dr;
        flush_i     = fl;
        #1;
        sz  = sb.size();
        rdy = (DEPTH - sz) >= 2;
        ev  = fl ? 2'b00 : (sz >= 2) ? 2'b11 : (sz >= 1) ? 2'b01 : 2'b00;
        check("count", 64'(count_o), 64'(sz));
        check("enq_ready", 64'(enq_ready_o), 64'(rdy));
        check("deq_valid", 64'(deq_valid_o), 64'(ev));
        n = int'(ev[0] & dr[0]) + int'(ev[1] & dr[1] & dr[0]);
        for (int i = 0; i < n; i++) begin
            e = sb.pop_front();
            check("deq_pc", 64'(deq_pc_o[i*32 +: 32]), 64'(e.pc));
            check("deq_inst", 64'(deq_inst_o[i*32 +: 32]), 64'(e.inst));
            check("deq_meta", 64'(deq_meta_o[i*META_W +: META_W]),
                  64'(e.meta));
        end
        if (fl) begin
            sb.delete();
        end else if ((|v) && rdy) begin
            for (int k = 0; k < 2; k++) begin
                if (v[k]) begin
                    e.pc   = {pc[31:3], 1'(k), 2'b00};
                    e.inst = inst[k*32 +: 32];
                    e.meta = meta;
                    sb.push_back(e);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [31:0] pc;
        n_chk       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        flush_i     = 1'b0;
        enq_valid_i = 2'b00;
        enq_pc_i    = '0;
        enq_inst_i  = '0;
        enq_meta_i  = '0;
        deq_ready_i = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_ready", 64'(enq_ready_o), 64'd1);
        check("rst_valid", 64'(deq_valid_o), 64'd0);
        check("rst_pc", deq_pc_o, 64'd0);
        check("rst_inst", deq_inst_o, 64'd0);
        check("rst_meta", 64'(deq_meta_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic full group
        step(2'b11, 32'h1c000000, 64'hbbbb_0002_aaaa_0001, 2'b00, 1'b0);
        check("tp1_pc", deq_pc_o, 64'h1c000004_1c000000);
        check("tp1_valid", 64'(deq_valid_o), 64'd3);
        step(2'b00, 32'h0, 64'h0, 2'b11, 1'b0);

        // Slot 1 only is compacted to the head
        step(2'b10, 32'h1c000004, 64'hbbbb_0002_dead_beef, 2'b00, 1'b0);
        check("tp2_pc", 64'(deq_pc_o[31:0]), 64'h1c000004);
        check("tp2_inst", 64'(deq_inst_o[31:0]), 64'hbbbb0002);
        step(2'b00, 32'h0, 64'h0, 2'b01, 1'b0);

        // Fill, overflow attempt, then drain one at a time
        pc = 32'h1c000100;
        for (int g = 0; g < 5; g++) begin
            step(2'b11, pc, rnd64(), 2'b00, 1'b0);
            pc += 32'd8;
        end
        step(2'b00, 32'h0, 64'h0, 2'b01, 1'b0);
        step(2'b00, 32'h0, 64'h0, 2'b01, 1'b0);
        check("tp3_ready6", 64'(enq_ready_o), 64'd1);

        // Steady two in, two out across the wrap
        pc = 32'h1c000120;
        for (int c = 0; c < 20; c++) begin
            step(2'b11, pc, rnd64(), 2'b11, 1'b0);
            pc += 32'd8;
        end
        check("tp4_count", 64'(count_o), 64'd6);

        // Flush at count five with colliding enqueue and dequeue
        step(2'b00, 32'h0, 64'h0, 2'b01, 1'b0);
        step(2'b11, 32'h20000000, rnd64(), 2'b11, 1'b1);
        check("tp5_count", 64'(count_o), 64'd0);
        step(2'b11, 32'h30000000, rnd64(), 2'b00, 1'b0);
        check("tp5_pc", 64'(deq_pc_o[31:0]), 64'h30000000);
        step(2'b01, 32'h30000008, rnd64(), 2'b11, 1'b0);
        step(2'b00, 32'h0, 64'h0, 2'b01, 1'b0);

        // Asynchronous reset with six entries held
        pc = 32'h1c000400;
        for (int g = 0; g < 3; g++) begin
            step(2'b11, pc, rnd64(), 2'b00, 1'b0);
            pc += 32'd8;
        end
        check("tp6_pre", 64'(count_o), 64'd6);
        #2;
        rst = 1'b1;
        #1;
        check("tp6_count", 64'(count_o), 64'd0);
        check("tp6_valid", 64'(deq_valid_o), 64'd0);
        check("tp6_pc", deq_pc_o, 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;

        // Recovery after reset
        step(2'b11, 32'h40000000, rnd64(), 2'b00, 1'b0);
        step(2'b00, 32'h0, 64'h0, 2'b11, 1'b0);
        step(2'b00, 32'h0, 64'h0, 2'b00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
